// File: rtl/counter_stream_checker.sv
// Receive-side checker for a free-running counter stream: locks onto the
// sequence, then flags mismatches, wraps and source restarts.
module counter_stream_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SYNC_LEN = 2,
  parameter int unsigned STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_valid,
  input  logic              clear,
  output logic              locked,
  output logic [WIDTH-1:0]  exp_count,
  output logic              err_pulse,
  output logic              restart_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  localparam int unsigned MW = 4;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  typedef enum logic [1:0] {S_UNLOCKED, S_SYNCING, S_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [MW-1:0]     match_q, match_d, match_inc;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_pulse_q, restart_pulse_q, locked_q;
  logic              err_hit, wrap_hit, restart_hit;

  // exp_q holds prev+1 directly, so it reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_UNLOCKED;
      exp_q           <= '0;
      match_q         <= '0;
      err_cnt_q       <= '0;
      wrap_cnt_q      <= '0;
      err_pulse_q     <= 1'b0;
      restart_pulse_q <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_q           <= exp_d;
      match_q         <= match_d;
      err_cnt_q       <= err_cnt_d;
      wrap_cnt_q      <= wrap_cnt_d;
      err_pulse_q     <= err_hit;
      restart_pulse_q <= restart_hit;
      locked_q        <= (state_d == S_LOCKED);
    end
  end

  // Next-state and event decode; invalid cycles leave everything untouched
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    match_inc   = MW'(match_q + MW'(1));
    err_hit     = 1'b0;
    wrap_hit    = 1'b0;
    restart_hit = 1'b0;
    if (count_valid) begin
      exp_d = WIDTH'(count_in + WIDTH'(1));
      case (state_q)
        S_UNLOCKED: begin
          match_d = '0;
          state_d = S_SYNCING;
        end
        S_SYNCING: begin
          if (count_in == exp_q) begin
            match_d = match_inc;
            if (match_inc == MW'(SYNC_LEN)) state_d = S_LOCKED;
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          if (count_in == exp_q) begin
            wrap_hit = (count_in == '0);
          end else if (count_in == '0) begin
            restart_hit = 1'b1;
          end else begin
            err_hit = 1'b1;
            match_d = '0;
            state_d = S_SYNCING;
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_comb begin
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (clear) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else begin
      if (err_hit && (err_cnt_q != STAT_MAX))
        err_cnt_d = STAT_W'(err_cnt_q + STAT_W'(1));
      if (wrap_hit && (wrap_cnt_q != STAT_MAX))
        wrap_cnt_d = STAT_W'(wrap_cnt_q + STAT_W'(1));
    end
  end

  assign locked        = locked_q;
  assign exp_count     = exp_q;
  assign err_pulse     = err_pulse_q;
  assign restart_pulse = restart_pulse_q;
  assign err_count     = err_cnt_q;
  assign wrap_count    = wrap_cnt_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed bench for counter_stream_checker (WIDTH=4, SYNC_LEN=2, STAT_W=2).
module tb_counter_stream_checker;

  logic       clk;
  logic       rst_n;
  logic [3:0] count_in;
  logic       count_valid;
  logic       clear;
  logic       locked;
  logic [3:0] exp_count;
  logic       err_pulse;
  logic       restart_pulse;
  logic [1:0] err_count;
  logic [1:0] wrap_count;

  int n_cmp;
  int n_bad;

  counter_stream_checker #(.WIDTH(4), .SYNC_LEN(2), .STAT_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_in      (count_in),
    .count_valid   (count_valid),
    .clear         (clear),
    .locked        (locked),
    .exp_count     (exp_count),
    .err_pulse     (err_pulse),
    .restart_pulse (restart_pulse),
    .err_count     (err_count),
    .wrap_count    (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic [3:0] val, input logic clr);
    @(negedge clk);
    count_valid = v;
    count_in    = val;
    clear       = clr;
    @(posedge clk);
    #1;
    count_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic state_chk(input string tag, input logic lk, input logic [3:0] ex,
                           input logic ep, input logic rp);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".exp"}, 32'(exp_count), 32'(ex));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
    check({tag, ".restart"}, 32'(restart_pulse), 32'(rp));
  endtask

  initial begin
    logic [3:0] c;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    count_in = '0;
    count_valid = 1'b0;
    clear = 1'b0;
    #12;
    state_chk("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    check("reset.err_count", 32'(err_count), 0);
    check("reset.wrap_count", 32'(wrap_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on 3,4,5
    step(1'b1, 4'd3, 1'b0); state_chk("cap3", 1'b0, 4'd4, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0); state_chk("sync4", 1'b0, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0); state_chk("lock5", 1'b1, 4'd6, 1'b0, 1'b0);
    for (int i = 6; i <= 15; i++) step(1'b1, 4'(i), 1'b0);
    check("pre_wrap.wrap_count", 32'(wrap_count), 0);
    step(1'b1, 4'd0, 1'b0); state_chk("wrap0", 1'b1, 4'd1, 1'b0, 1'b0);
    check("wrap0.wrap_count", 32'(wrap_count), 1);
    step(1'b1, 4'd1, 1'b0); state_chk("track1", 1'b1, 4'd2, 1'b0, 1'b0);
    check("track1.err_count", 32'(err_count), 0);

    // Mismatch at exp 8, then relock
    for (int i = 2; i <= 7; i++) step(1'b1, 4'(i), 1'b0);
    check("pre_mis.exp", 32'(exp_count), 8);
    step(1'b1, 4'd11, 1'b0); state_chk("mis11", 1'b0, 4'd12, 1'b1, 1'b0);
    check("mis11.err_count", 32'(err_count), 1);
    step(1'b1, 4'd12, 1'b0); state_chk("resync12", 1'b0, 4'd13, 1'b0, 1'b0);
    step(1'b1, 4'd13, 1'b0); state_chk("relock13", 1'b1, 4'd14, 1'b0, 1'b0);

    // Valid gaps are transparent
    step(1'b1, 4'd14, 1'b0);
    step(1'b0, 4'd9, 1'b0); state_chk("gap1", 1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b0, 4'd3, 1'b0); state_chk("gap2", 1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b1, 4'd15, 1'b0); state_chk("after_gap", 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    check("wrap2.wrap_count", 32'(wrap_count), 2);

    // Source restart at exp 9
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd0, 1'b0); state_chk("restart", 1'b1, 4'd1, 1'b0, 1'b1);
    check("restart.err_count", 32'(err_count), 1);
    check("restart.wrap_count", 32'(wrap_count), 2);
    step(1'b1, 4'd1, 1'b0); state_chk("post_restart", 1'b1, 4'd2, 1'b0, 1'b0);

    // Second mismatch, relock, then clear colliding with a mismatch
    step(1'b1, 4'd9, 1'b0); state_chk("mis9", 1'b0, 4'd10, 1'b1, 1'b0);
    check("mis9.err_count", 32'(err_count), 2);
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd11, 1'b0); state_chk("relock11", 1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b1); state_chk("clr_mis", 1'b0, 4'd6, 1'b1, 1'b0);
    check("clr_mis.err_count", 32'(err_count), 0);
    check("clr_mis.wrap_count", 32'(wrap_count), 0);

    // Saturation: five mismatches with relocks in between
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd7, 1'b0); state_chk("sat_lock", 1'b1, 4'd8, 1'b0, 1'b0);
    c = 4'd11;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, c, 1'b0);
      check("sat.err_pulse", 32'(err_pulse), 1);
      check("sat.err_count", 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      step(1'b1, 4'(c + 4'd1), 1'b0);
      step(1'b1, 4'(c + 4'd2), 1'b0);
      check("sat.relock", 32'(locked), 1);
      c = 4'(c + 4'd6);
    end

    // Asynchronous reset between edges while locked
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    state_chk("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    check("async_rst.err_count", 32'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd7, 1'b0); state_chk("rcap7", 1'b0, 4'd8, 1'b0, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0); state_chk("rlock9", 1'b1, 4'd10, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
